// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then shift one byte
// with odd parity to the device on its own clock and collect the ACK bit.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic       ps2clk_low,
    output logic       ps2data_low,
    output logic       busy,
    output logic       done,
    output logic [1:0] err_code
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        WAIT_REL,
        ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [INH_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic [3:0]        fe_cnt_q, fe_cnt_d;
    logic [7:0]        data_q, data_d;
    logic              par_q, par_d;
    logic              dlow_q, dlow_d;
    logic              nack_q, nack_d;
    logic [1:0]        err_q, err_d;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;

    logic       fe;
    logic       clk_edge;
    logic       timeout;
    logic [3:0] fe_next;
    logic [2:0] bit_idx;

    assign fe       = clk_prev_q & ~clk_sync_q;
    assign clk_edge = clk_prev_q ^ clk_sync_q;
    assign fe_next  = fe_cnt_q + 4'd1;
    // fe 1..8 map to bits 0..7; fe 8 wraps fe_next[2:0] to 0, so minus one gives 7
    assign bit_idx  = fe_next[2:0] - 3'd1;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;
        fe_cnt_d    = fe_cnt_q;
        data_d      = data_q;
        par_d       = par_q;
        dlow_d      = dlow_q;
        nack_d      = nack_q;
        err_d       = err_q;
        tx_ready    = 1'b0;
        ps2clk_low  = 1'b0;
        ps2data_low = 1'b0;
        done        = 1'b0;
        err_code    = err_q;
        timeout     = 1'b0;

        if (state_q == SEND || state_q == WAIT_REL) begin
            wd_d    = clk_edge ? '0 : wd_q + TO_W'(1);
            timeout = !clk_edge && (wd_q == TO_LAST);
        end

        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    data_d  = tx_data;
                    par_d   = ~^tx_data;
                    cnt_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2clk_low = 1'b1;
                if (cnt_q == INH_LAST) state_d = REQ;
                else                   cnt_d   = cnt_q + INH_W'(1);
            end
            REQ: begin
                ps2clk_low  = 1'b1;
                ps2data_low = 1'b1;
                dlow_d      = 1'b1;
                fe_cnt_d    = '0;
                wd_d        = '0;
                state_d     = SEND;
            end
            SEND: begin
                ps2data_low = dlow_q;
                if (timeout) begin
                    state_d = ERROR;
                end else if (fe) begin
                    fe_cnt_d = fe_next;
                    if (fe_next <= 4'd8)       dlow_d = ~data_q[bit_idx];
                    else if (fe_next == 4'd9)  dlow_d = ~par_q;
                    else if (fe_next == 4'd10) dlow_d = 1'b0;
                    else begin
                        dlow_d  = 1'b0;
                        nack_d  = data_sync_q;
                        state_d = WAIT_REL;
                    end
                end
            end
            WAIT_REL: begin
                if (timeout) begin
                    state_d = ERROR;
                end else if (clk_sync_q && data_sync_q) begin
                    done     = 1'b1;
                    err_d    = {1'b0, nack_q};
                    err_code = {1'b0, nack_q};
                    state_d  = IDLE;
                end
            end
            ERROR: begin
                done     = 1'b1;
                err_d    = 2'b10;
                err_code = 2'b10;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchronizers idle high so a released bus produces no edge out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wd_q        <= '0;
            fe_cnt_q    <= '0;
            dlow_q      <= 1'b0;
            nack_q      <= 1'b0;
            err_q       <= 2'b00;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            fe_cnt_q    <= fe_cnt_d;
            dlow_q      <= dlow_d;
            nack_q      <= nack_d;
            err_q       <= err_d;
            clk_meta_q  <= PS2Clk;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= PS2Data;
            data_sync_q <= data_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        par_q  <= par_d;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard that clocks
// the frame in, plus a queue of expected bytes and completion codes.
module tb_ps2_host_tx;

    localparam int INH  = 100;
    localparam int TO   = 1000;
    localparam int HALF = 30;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       PS2Clk;
    logic       PS2Data;
    logic       ps2clk_low;
    logic       ps2data_low;
    logic       busy;
    logic       done;
    logic [1:0] err_code;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;

    typedef struct {
        logic [7:0] data;
        logic [1:0] err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Wired-AND bus with external pull-ups
    assign PS2Clk  = dev_clk & ~ps2clk_low;
    assign PS2Data = dev_data & ~ps2data_low;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .PS2Clk     (PS2Clk),
        .PS2Data    (PS2Data),
        .ps2clk_low (ps2clk_low),
        .ps2data_low(ps2data_low),
        .busy       (busy),
        .done       (done),
        .err_code   (err_code)
    );

    task automatic send_byte(input logic [7:0] b, input logic [1:0] err);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (tx_ready !== 1'b1) $display("FAIL send_ready: tx_ready=%b required 1", tx_ready);
        else n_pass++;
        tx_data  = b;
        tx_valid = 1'b1;
        exp_q.push_back('{b, err});
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    // Keyboard side: reads the start bit, then clocks bits out after each falling edge.
    task automatic dev_frame(input logic nack, input int stop_at,
                             output logic [10:0] bits, output logic ok);
        int n = 0;
        ok   = 1'b1;
        bits = '1;
        while (PS2Clk !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (PS2Clk !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        repeat (20) @(negedge clk);
        bits[0] = PS2Data;
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) begin
                dev_data = nack;
                repeat (5) @(negedge clk);
            end
            dev_clk = 1'b0;
            if (i == stop_at) begin
                repeat (6) @(negedge clk);
                return;
            end
            repeat (HALF) @(negedge clk);
            if (i <= 10) bits[i] = PS2Data;
            dev_clk = 1'b1;
            if (i == 11) dev_data = 1'b1;
            else repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic complete_frame(input logic nack);
        logic [10:0] bits;
        logic        ok;
        exp_t        e;
        int          n = 0;
        dev_frame(nack, 0, bits, ok);
        n_checks++;
        if (ok !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL frame_start: clock_released=%b queued=%0d required 1 and >0", ok, exp_q.size());
            return;
        end
        n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (bits[0] !== 1'b0) $display("FAIL start_bit: got %b required 0", bits[0]);
        else n_pass++;
        n_checks++;
        if (bits[8:1] !== e.data) $display("FAIL data_bits: got %h required %h", bits[8:1], e.data);
        else n_pass++;
        n_checks++;
        if (bits[9] !== ~^e.data) $display("FAIL parity_bit: got %b required %b", bits[9], ~^e.data);
        else n_pass++;
        n_checks++;
        if (bits[10] !== 1'b1) $display("FAIL stop_bit: got %b required 1", bits[10]);
        else n_pass++;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL done_seen: done=%b required 1 within 200 cycles", done);
        else n_pass++;
        n_checks++;
        if (err_code !== e.err) $display("FAIL err_code: got %b required %b", err_code, e.err);
        else n_pass++;
        n_checks++;
        if (tx_ready !== 1'b0) $display("FAIL ready_in_done: tx_ready=%b required 0", tx_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL idle_after_done: tx_ready=%b busy=%b required 1 0", tx_ready, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx_ready, busy, done, ps2clk_low, ps2data_low} !== 5'b10000)
            $display("FAIL reset_outputs: ready,busy,done,clk_low,data_low=%b required 10000",
                     {tx_ready, busy, done, ps2clk_low, ps2data_low});
        else n_pass++;
        n_checks++;
        if (err_code !== 2'b00) $display("FAIL reset_err: got %b required 00", err_code);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL post_reset_idle: tx_ready=%b busy=%b required 1 0", tx_ready, busy);
        else n_pass++;
    endtask

    task automatic test_send_ed();
        int n = 0;
        send_byte(8'hED, 2'b00);
        while (ps2clk_low === 1'b1 && ps2data_low === 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n != INH) $display("FAIL inhibit_len: got %0d cycles required %0d", n, INH);
        else n_pass++;
        n_checks++;
        if (ps2clk_low !== 1'b1 || ps2data_low !== 1'b1)
            $display("FAIL req_cycle: clk_low=%b data_low=%b required 1 1", ps2clk_low, ps2data_low);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ps2clk_low !== 1'b0 || ps2data_low !== 1'b1)
            $display("FAIL clk_release: clk_low=%b data_low=%b required 0 1", ps2clk_low, ps2data_low);
        else n_pass++;
        complete_frame(1'b0);
    endtask

    task automatic test_send_f4();
        send_byte(8'hF4, 2'b00);
        complete_frame(1'b0);
    endtask

    task automatic test_timeout();
        exp_t e;
        int   n = 0;
        send_byte(8'hA5, 2'b10);
        while (ps2clk_low === 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        // The host's own clock release takes a few cycles to pass the synchronizer
        n_checks++;
        if (n < TO || n > TO + 4) $display("FAIL timeout_len: got %0d cycles required %0d..%0d", n, TO, TO + 4);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (done !== 1'b1 || err_code !== e.err)
            $display("FAIL timeout_err: done=%b err_code=%b required 1 %b", done, err_code, e.err);
        else n_pass++;
        n_checks++;
        if (ps2clk_low !== 1'b0 || ps2data_low !== 1'b0)
            $display("FAIL timeout_release: clk_low=%b data_low=%b required 0 0", ps2clk_low, ps2data_low);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (tx_ready !== 1'b1) $display("FAIL timeout_ready: tx_ready=%b required 1", tx_ready);
        else n_pass++;
    endtask

    task automatic test_nack();
        send_byte(8'h3C, 2'b01);
        complete_frame(1'b1);
        repeat (20) @(negedge clk);
        n_checks++;
        if (err_code !== 2'b01) $display("FAIL err_hold: got %b required 01", err_code);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [10:0] bits;
        logic        ok;
        exp_t        e;
        send_byte(8'hED, 2'b00);
        dev_frame(1'b0, 5, bits, ok);
        // 0xED bit 4 is 0, so the host is pulling data low here
        n_checks++;
        if (ok !== 1'b1 || ps2data_low !== 1'b1)
            $display("FAIL prereset_drive: ok=%b data_low=%b required 1 1", ok, ps2data_low);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ps2clk_low !== 1'b0 || ps2data_low !== 1'b0)
            $display("FAIL async_release: clk_low=%b data_low=%b required 0 0", ps2clk_low, ps2data_low);
        else n_pass++;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        e = exp_q.pop_front();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_recover: tx_ready=%b busy=%b required 1 0", tx_ready, busy);
        else n_pass++;
        send_byte(8'hED, 2'b00);
        complete_frame(1'b0);
    endtask

    task automatic test_busy_ignore();
        logic ready_seen = 1'b0;
        int   extra      = 0;
        send_byte(8'hED, 2'b00);
        for (int i = 0; i < 5; i++) begin
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            @(negedge clk);
            if (tx_ready !== 1'b0 || busy !== 1'b1) ready_seen = 1'b1;
        end
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        n_checks++;
        if (ready_seen !== 1'b0) $display("FAIL busy_ready: tx_ready high or busy low while framing, required 0 1");
        else n_pass++;
        complete_frame(1'b0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        n_checks++;
        if (extra != 0 || exp_q.size() != 0)
            $display("FAIL single_done: extra_cycles=%0d queued=%0d required 0 0", extra, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_send_f4();
        test_timeout();
        test_nack();
        test_reset_midframe();
        test_busy_ignore();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
